// File: rtl/clock_pkg.sv
// Shared digital-clock package: per-stage moduli/widths and the count-direction type.
// Imported by the modulo counter, its next-state helper and its bus interface.
package clock_pkg;

  localparam int unsigned SEC_MODULUS  = 60;
  localparam int unsigned MIN_MODULUS  = 60;
  localparam int unsigned HOUR_MODULUS = 24;
  localparam int unsigned SEC_WIDTH    = 6;
  localparam int unsigned HOUR_WIDTH   = 5;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } count_dir_t;

endpackage

// File: rtl/modulo_tick_counter_if.sv
// Bus bundle between a modulo tick counter (slave) and whatever drives it (master).
//   Tick, Load, Load_value, Down : master -> counter
//   Q, Terminal, Carry, Load_err : counter -> master
// Down exists only when MODCNT_DOWN_EN is defined.
interface modulo_tick_counter_if #(
  parameter int unsigned WIDTH = 6
) ();

  logic             Tick;
  logic             Load;
  logic [WIDTH-1:0] Load_value;
`ifdef MODCNT_DOWN_EN
  logic             Down;
`endif
  logic [WIDTH-1:0] Q;
  logic             Terminal;
  logic             Carry;
  logic             Load_err;

`ifdef MODCNT_DOWN_EN
  modport master (output Tick, Load, Load_value, Down,
                  input  Q, Terminal, Carry, Load_err);
  modport slave  (input  Tick, Load, Load_value, Down,
                  output Q, Terminal, Carry, Load_err);
`else
  modport master (output Tick, Load, Load_value,
                  input  Q, Terminal, Carry, Load_err);
  modport slave  (input  Tick, Load, Load_value,
                  output Q, Terminal, Carry, Load_err);
`endif

endinterface

// File: rtl/modcnt_next.sv
// Combinational next-count for a modulo counter.
//   q_i        : current count
//   dir_i      : count direction
//   q_next_o   : count after one tick in dir_i
//   wrap_o     : the tick wraps (up at MODULUS-1, down at 0)
//   terminal_o : q_i is the last value before a wrap in dir_i
module modcnt_next
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 60
) (
  input  logic [WIDTH-1:0] q_i,
  input  count_dir_t       dir_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             wrap_o,
  output logic             terminal_o
);

  localparam int unsigned     WP1  = WIDTH + 1;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] q_inc;
  logic           at_last;
  logic           at_zero;

  // Extra bit keeps the increment exact when MODULUS == 2**WIDTH.
  assign q_inc   = {1'b0, q_i} + WP1'(1);
  assign at_last = (q_i == LAST);
  assign at_zero = (q_i == '0);

  always_comb begin
    q_next_o   = WIDTH'(q_inc);
    wrap_o     = 1'b0;
    terminal_o = at_last;
    if (dir_i == DIR_DOWN) begin
      terminal_o = at_zero;
      if (at_zero) begin
        q_next_o = LAST;
        wrap_o   = 1'b1;
      end else begin
        q_next_o = q_i - WIDTH'(1);
      end
    end else if (at_last) begin
      q_next_o = '0;
      wrap_o   = 1'b1;
    end
  end

endmodule

// File: rtl/modulo_tick_counter.sv
// Modulo-MODULUS tick counter stage for the digital-clock datapath.
//   Clock : posedge clock
//   Reset : synchronous active-low reset
//   bus   : slave side of modulo_tick_counter_if (Tick/Load/Load_value[/Down] in;
//           Q, Terminal (combinational), Carry, Load_err out)
// Build option MODCNT_DOWN_EN adds the Down input and down counting with borrow.
module modulo_tick_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned MODULUS     = 60,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  modulo_tick_counter_if.slave          bus
);

  localparam int unsigned WP1 = WIDTH + 1;

  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("modulo_tick_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("modulo_tick_counter: RESET_VALUE must be below MODULUS");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] q_next;
  logic             wrap;
  logic             load_ok;
  count_dir_t       dir;

`ifdef MODCNT_DOWN_EN
  assign dir = bus.Down ? DIR_DOWN : DIR_UP;
`else
  assign dir = DIR_UP;
`endif

  modcnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q_i        (q_q),
    .dir_i      (dir),
    .q_next_o   (q_next),
    .wrap_o     (wrap),
    .terminal_o (bus.Terminal)
  );

  assign load_ok = ({1'b0, bus.Load_value} < WP1'(MODULUS));

  // Priority mux: Load beats Tick; otherwise hold.
  always_comb begin
    q_d        = q_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.Load) begin
      if (load_ok) begin
        q_d = bus.Load_value;
      end else begin
        q_d        = '0;
        load_err_d = 1'b1;
      end
    end else if (bus.Tick) begin
      q_d     = q_next;
      carry_d = wrap;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      q_q        <= WIDTH'(RESET_VALUE);
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.Carry    = carry_q;
  assign bus.Load_err = load_err_q;

endmodule

// File: tb/tb_modulo_tick_counter.sv
module tb_modulo_tick_counter;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_pass;

  modulo_tick_counter_if #(.WIDTH(6)) if60 ();
  modulo_tick_counter_if #(.WIDTH(6)) if64 ();
  modulo_tick_counter_if #(.WIDTH(5)) if24 ();

  modulo_tick_counter #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0))
    dut60 (.Clock(Clock), .Reset(Reset), .bus(if60.slave));
  modulo_tick_counter #(.WIDTH(6), .MODULUS(64), .RESET_VALUE(0))
    dut64 (.Clock(Clock), .Reset(Reset), .bus(if64.slave));
  modulo_tick_counter #(.WIDTH(5), .MODULUS(24), .RESET_VALUE(0))
    dut24 (.Clock(Clock), .Reset(Reset), .bus(if24.slave));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%h) expected %0d", tag, got, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b0;
    if60.Tick = 0; if60.Load = 0; if60.Load_value = '0;
    if64.Tick = 0; if64.Load = 0; if64.Load_value = '0;
    if24.Tick = 0; if24.Load = 0; if24.Load_value = '0;
`ifdef MODCNT_DOWN_EN
    if60.Down = 0; if64.Down = 0; if24.Down = 0;
`endif
    step(); step();
    check("rst_q",        32'(if60.Q), 0);
    check("rst_carry",    32'(if60.Carry), 0);
    check("rst_load_err", 32'(if60.Load_err), 0);
    check("rst_terminal", 32'(if60.Terminal), 0);
    check("rst_q64",      32'(if64.Q), 0);
    check("rst_q24",      32'(if24.Q), 0);

    // Full mod-60 cycle.
    Reset = 1'b1;
    if60.Tick = 1;
    for (int i = 1; i <= 60; i++) begin
      step();
      check("run_q",     32'(if60.Q), 32'(i % 60));
      check("run_carry", 32'(if60.Carry), (i == 60) ? 32'd1 : 32'd0);
      check("run_term",  32'(if60.Terminal), (i == 59) ? 32'd1 : 32'd0);
    end
    if60.Tick = 0;
    step();
    check("hold_q",     32'(if60.Q), 0);
    check("hold_carry", 32'(if60.Carry), 0);

    // Load and Tick together: load wins.
    if60.Tick = 1; if60.Load = 1; if60.Load_value = 6'd17;
    step();
    check("ld_q",     32'(if60.Q), 17);
    check("ld_carry", 32'(if60.Carry), 0);
    check("ld_err",   32'(if60.Load_err), 0);
    if60.Load = 0;
    step();
    check("ld_tick_q", 32'(if60.Q), 18);
    if60.Tick = 0;

    // Out-of-range load.
    if60.Load = 1; if60.Load_value = 6'd61;
    step();
    check("bad_ld_q",   32'(if60.Q), 0);
    check("bad_ld_err", 32'(if60.Load_err), 1);
    if60.Load = 0;
    step();
    check("bad_ld_err_clr", 32'(if60.Load_err), 0);
    check("bad_ld_q_hold",  32'(if60.Q), 0);

    // Largest legal load value.
    if60.Load = 1; if60.Load_value = 6'd59;
    step();
    check("ld59_q",    32'(if60.Q), 59);
    check("ld59_err",  32'(if60.Load_err), 0);
    check("ld59_term", 32'(if60.Terminal), 1);
    if60.Load = 0;

    // Reset with Tick at Q=59: no wrap, no carry.
    if60.Tick = 1; Reset = 1'b0;
    step();
    check("rst_tick_q",     32'(if60.Q), 0);
    check("rst_tick_carry", 32'(if60.Carry), 0);
    Reset = 1'b1; if60.Tick = 0;

    // Reset is not asynchronous.
    if60.Load = 1; if60.Load_value = 6'd30;
    step();
    if60.Load = 0;
    Reset = 1'b0;
    #2;
    check("rst_sync_hold", 32'(if60.Q), 30);
    step();
    check("rst_sync_q", 32'(if60.Q), 0);
    Reset = 1'b1;

    // MODULUS == 2**WIDTH.
    if64.Load = 1; if64.Load_value = 6'd63;
    step();
    check("m64_ld_q",   32'(if64.Q), 63);
    check("m64_ld_err", 32'(if64.Load_err), 0);
    check("m64_term",   32'(if64.Terminal), 1);
    if64.Load = 0; if64.Tick = 1;
    step();
    check("m64_wrap_q",     32'(if64.Q), 0);
    check("m64_wrap_carry", 32'(if64.Carry), 1);
    step();
    check("m64_next_q",     32'(if64.Q), 1);
    check("m64_next_carry", 32'(if64.Carry), 0);
    if64.Tick = 0;

    // Mod-24 stage.
    if24.Load = 1; if24.Load_value = 5'd24;
    step();
    check("m24_bad_q",   32'(if24.Q), 0);
    check("m24_bad_err", 32'(if24.Load_err), 1);
    if24.Load = 0;
`ifdef MODCNT_DOWN_EN
    if24.Down = 1;
    #1;
    check("m24_dn_term0", 32'(if24.Terminal), 1);
    if24.Tick = 1;
    step();
    check("m24_borrow_q",     32'(if24.Q), 23);
    check("m24_borrow_carry", 32'(if24.Carry), 1);
    check("m24_dn_term23",    32'(if24.Terminal), 0);
    if24.Down = 0;
    #1;
    check("m24_up_term23", 32'(if24.Terminal), 1);
    step();
    check("m24_up_wrap_q",     32'(if24.Q), 0);
    check("m24_up_wrap_carry", 32'(if24.Carry), 1);
    if24.Down = 1;
    step();
    check("m24_dn_again_q", 32'(if24.Q), 23);
    if24.Tick = 0;
    step();
    check("m24_dn_hold_carry", 32'(if24.Carry), 0);
`else
    if24.Load = 1; if24.Load_value = 5'd23;
    step();
    check("m24_ld_q",  32'(if24.Q), 23);
    check("m24_term",  32'(if24.Terminal), 1);
    if24.Load = 0; if24.Tick = 1;
    step();
    check("m24_wrap_q",     32'(if24.Q), 0);
    check("m24_wrap_carry", 32'(if24.Carry), 1);
    if24.Tick = 0;
    step();
    check("m24_hold_carry", 32'(if24.Carry), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
